// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Requester-side bus of the three-port memory arbiter. Port i occupies
// bit i of req/we/gnt/ack and slice i of the packed addr/wdata vectors.
// The master modport belongs to the requesters; the slave modport belongs to the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      owner;
    logic            busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata, owner, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata, owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory among instruction fetch (port 0), load/store
// (port 1) and debug/loader (port 2). A request is arbitrated in IDLE and latched.
// It then spends MEM_LAT cycles in ACCESS and is acknowledged for one cycle in DONE.
// All outputs are registered.
// Configuration macro: MEMARB_RR_EN
//   undefined -> fixed priority, port 2 > port 1 > port 0
//   defined   -> round-robin starting after the last winner (pointer resets to 2)
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_port_arbiter_if.slave        port,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata
);
    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      owner_q, owner_d;
    logic            busy_q, busy_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]      winner_s;

`ifdef MEMARB_RR_EN
    logic [1:0]      ptr_q, ptr_d;

    // Round-robin pick: scan (ptr+1) mod 3 upward with wrap; first requester wins.
    function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        idx   = ptr;
        res   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (r[idx] && !found) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    assign winner_s = pick_rr(port.req, ptr_q);
`else
    // Fixed priority pick: port 2 beats port 1 beats port 0.
    function automatic logic [1:0] pick_fixed(input logic [2:0] r);
        logic [1:0] res;
        if (r[2]) begin
            res = 2'd2;
        end else if (r[1]) begin
            res = 2'd1;
        end else begin
            res = 2'd0;
        end
        return res;
    endfunction

    assign winner_s = pick_fixed(port.req);
`endif

    // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = 3'b000;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        owner_d     = owner_q;
        busy_d      = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef MEMARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (port.req != 3'b000) begin
                    // The mem_* flops double as the latch for the winning request.
                    state_d     = ST_ACCESS;
                    cnt_d       = CNT_INIT;
                    gnt_d       = 3'b001 << winner_s;
                    owner_d     = winner_s;
                    busy_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = port.we[winner_s];
                    mem_addr_d  = port.addr[int'(winner_s)*AW +: AW];
                    mem_wdata_d = port.wdata[int'(winner_s)*DW +: DW];
`ifdef MEMARB_RR_EN
                    ptr_d       = winner_s;
`endif
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_ZERO) begin
                    // Last access cycle: data is valid at this edge; release the memory.
                    state_d = ST_DONE;
                    ack_d   = 3'b001 << owner_q;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d       = cnt_q - CNT_ONE;
                    mem_en_d    = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            gnt_q       <= 3'b000;
            ack_q       <= 3'b000;
            rdata_q     <= '0;
            owner_q     <= 2'd0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MEMARB_RR_EN
    // Round-robin pointer; resets to 2 so port 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd2;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign port.gnt   = gnt_q;
    assign port.ack   = ack_q;
    assign port.rdata = rdata_q;
    assign port.owner = owner_q;
    assign port.busy  = busy_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (MEM_LAT=2). Directed scenarios plus a
// randomized run checked against a transaction-level model of arbitration and timing.
module tb_mem_port_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;
`ifdef MEMARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_init;
    logic [DW-1:0]   mem [0:255];
    logic [DW-1:0]   ref_mem [0:255];
    int              n_cmp = 0;
    int              n_err = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .port      (bus.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'hC0DE0000 + 32'(a * 7);
    endfunction

    // Memory model: combinational read of mem[addr], write on enabled write cycles.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    function automatic int pick(input logic [2:0] r, input int ptr);
        for (int i = 0; i < 3; i++) begin
            int c;
            c = RR_MODE ? (ptr + 1 + i) % 3 : 2 - i;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic int gidx(input logic [2:0] g);
        if (g[2]) return 2;
        if (g[1]) return 1;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[p]             = r;
        bus.we[p]              = w;
        bus.addr[p*AW +: AW]   = a;
        bus.wdata[p*DW +: DW]  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1;
        bus.req = 3'b111; bus.we = 3'b000; bus.addr = '0; bus.wdata = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if ({bus.gnt, bus.ack, mem_en, mem_we, bus.busy, bus.owner, bus.rdata, mem_addr} !==
                {3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0}) begin
                n_err++;
                $display("FAIL reset: gnt=%b ack=%b mem_en=%b mem_we=%b busy=%b owner=%0d rdata=%h mem_addr=%h, expected all zero",
                         bus.gnt, bus.ack, mem_en, mem_we, bus.busy, bus.owner, bus.rdata, mem_addr);
            end
        end
        mem_init = 1'b0; bus.req = 3'b000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_read();
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        step();
        n_cmp++;
        if ({bus.gnt, mem_en, mem_we, mem_addr, bus.owner, bus.busy, bus.ack} !==
            {3'b010, 1'b1, 1'b0, 32'h10, 2'd1, 1'b1, 3'b000}) begin
            n_err++;
            $display("FAIL read_c1: gnt=%b en=%b we=%b addr=%h owner=%0d busy=%b ack=%b, expected 010 1 0 10 1 1 000",
                     bus.gnt, mem_en, mem_we, mem_addr, bus.owner, bus.busy, bus.ack);
        end
        bus.req = 3'b000;
        step();
        n_cmp++;
        if ({bus.gnt, mem_en, mem_addr, bus.ack} !== {3'b000, 1'b1, 32'h10, 3'b000}) begin
            n_err++;
            $display("FAIL read_c2: gnt=%b en=%b addr=%h ack=%b, expected 000 1 10 000",
                     bus.gnt, mem_en, mem_addr, bus.ack);
        end
        step();
        n_cmp++;
        if ({bus.ack, bus.rdata, mem_en, bus.busy} !== {3'b010, 32'hDEADBEEF, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL read_c3: ack=%b rdata=%h en=%b busy=%b, expected 010 deadbeef 0 1",
                     bus.ack, bus.rdata, mem_en, bus.busy);
        end
        step();
        n_cmp++;
        if ({bus.ack, bus.busy} !== {3'b000, 1'b0}) begin
            n_err++;
            $display("FAIL read_c4: ack=%b busy=%b, expected 000 0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_write();
        drive(0, 1'b1, 1'b1, 32'h4, 32'h1234);
        step();
        n_cmp++;
        if ({bus.gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b001, 1'b1, 1'b1, 32'h4, 32'h1234}) begin
            n_err++;
            $display("FAIL write_c1: gnt=%b en=%b we=%b addr=%h wdata=%h, expected 001 1 1 4 1234",
                     bus.gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        bus.req = 3'b000;
        step();
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h4}) begin
            n_err++;
            $display("FAIL write_c2: en=%b we=%b addr=%h, expected 1 1 4", mem_en, mem_we, mem_addr);
        end
        step();
        n_cmp++;
        if ({bus.ack, bus.rdata, mem_en, mem_we} !== {3'b001, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL write_ack: ack=%b rdata=%h en=%b we=%b, expected 001 deadbeef 0 0",
                     bus.ack, bus.rdata, mem_en, mem_we);
        end
        step();
        drive(0, 1'b1, 1'b0, 32'h4, 32'h0);
        step();
        bus.req = 3'b000;
        step();
        step();
        n_cmp++;
        if ({bus.ack, bus.rdata} !== {3'b001, 32'h1234}) begin
            n_err++;
            $display("FAIL write_readback: ack=%b rdata=%h, expected 001 00001234", bus.ack, bus.rdata);
        end
        step();
    endtask

    task automatic test_priority();
        int order[3];
        int gcyc[3];
        int exp_order[3];
        int n = 0;
        int acks_since = 0;
        bit ack_ok = 1'b1;
        if (RR_MODE) exp_order = '{0, 1, 2};
        else         exp_order = '{2, 1, 0};
        order = '{-1, -1, -1};
        gcyc  = '{0, 0, 0};
        reset = 1'b1; step(); reset = 1'b0;
        for (int p = 0; p < 3; p++) drive(p, 1'b1, 1'b0, 32'(32 + p), 32'h0);
        for (int c = 1; c <= 30 && n < 3; c++) begin
            step();
            if (bus.ack != 3'b000) acks_since++;
            if (bus.gnt != 3'b000) begin
                if (n > 0 && acks_since != 1) ack_ok = 1'b0;
                acks_since = 0;
                order[n] = gidx(bus.gnt);
                gcyc[n]  = c;
                bus.req[gidx(bus.gnt)] = 1'b0;
                n++;
            end
        end
        n_cmp++;
        if (n != 3) begin
            n_err++;
            $display("FAIL prio_count: grants=%0d, expected 3 within 30 cycles", n);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (order[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL prio_order[%0d]: port=%0d, expected %0d", i, order[i], exp_order[i]);
            end
        end
        for (int i = 1; i < n; i++) begin
            n_cmp++;
            if (gcyc[i] - gcyc[i-1] != MEM_LAT + 2) begin
                n_err++;
                $display("FAIL prio_spacing[%0d]: %0d cycles, expected %0d", i, gcyc[i] - gcyc[i-1], MEM_LAT + 2);
            end
        end
        n_cmp++;
        if (!ack_ok) begin
            n_err++;
            $display("FAIL prio_ack_between: ack_ok=%b, expected 1", ack_ok);
        end
        repeat (4) step();
    endtask

    task automatic test_reset_abort();
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        step();
        n_cmp++;
        if (bus.gnt !== 3'b010) begin
            n_err++;
            $display("FAIL abort_gnt: gnt=%b, expected 010", bus.gnt);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({mem_en, bus.busy, bus.ack, bus.gnt} !== {1'b0, 1'b0, 3'b000, 3'b000}) begin
            n_err++;
            $display("FAIL abort_reset: en=%b busy=%b ack=%b gnt=%b, expected 0 0 000 000",
                     mem_en, bus.busy, bus.ack, bus.gnt);
        end
        step();
        n_cmp++;
        if ({bus.gnt, mem_en, bus.ack} !== {3'b010, 1'b1, 3'b000}) begin
            n_err++;
            $display("FAIL abort_regrant: gnt=%b en=%b ack=%b, expected 010 1 000", bus.gnt, mem_en, bus.ack);
        end
        bus.req = 3'b000;
        step();
        step();
        n_cmp++;
        if ({bus.ack, bus.rdata} !== {3'b010, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL abort_ack: ack=%b rdata=%h, expected 010 deadbeef", bus.ack, bus.rdata);
        end
        step();
    endtask

    task automatic test_rerequest();
        int order[6];
        int exp_order[6];
        int gcyc[6];
        int n = 0;
        if (RR_MODE) exp_order = '{0, 1, 2, 0, 1, 2};
        else         exp_order = '{2, 2, 2, 2, 2, 2};
        order = '{-1, -1, -1, -1, -1, -1};
        gcyc  = '{0, 0, 0, 0, 0, 0};
        reset = 1'b1; step(); reset = 1'b0;
        for (int p = 0; p < 3; p++) drive(p, 1'b1, 1'b0, 32'(48 + p), 32'h0);
        for (int c = 1; c <= 60 && n < 6; c++) begin
            step();
            if (bus.ack != 3'b000) bus.req = 3'b111;
            if (bus.gnt != 3'b000) begin
                order[n] = gidx(bus.gnt);
                gcyc[n]  = c;
                bus.req[gidx(bus.gnt)] = 1'b0;
                n++;
            end
        end
        bus.req = 3'b000;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (order[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL rereq_order[%0d]: port=%0d, expected %0d", i, order[i], exp_order[i]);
            end
        end
        for (int i = 1; i < n; i++) begin
            n_cmp++;
            if (gcyc[i] - gcyc[i-1] != MEM_LAT + 2) begin
                n_err++;
                $display("FAIL rereq_spacing[%0d]: %0d cycles, expected %0d", i, gcyc[i] - gcyc[i-1], MEM_LAT + 2);
            end
        end
        repeat (4) step();
    endtask

    task automatic test_random();
        logic [2:0]      pend = 3'b000;
        logic [2:0]      req_s, we_s;
        logic [3*AW-1:0] addr_s;
        logic [3*DW-1:0] wdata_s;
        int              k = 0, next_dec = 1, g = -1000, ptr = 2, t_port = 0, exp_owner = 0;
        logic            t_we = 1'b0;
        logic [AW-1:0]   t_addr = '0;
        logic [DW-1:0]   t_wdata = '0, exp_rdata = '0;
        logic [2:0]      exp_gnt, exp_ack;
        logic            exp_en, exp_busy;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus.req = 3'b000;
        reset = 1'b1; mem_init = 1'b1;
        step();
        reset = 1'b0; mem_init = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req_s = bus.req; we_s = bus.we; addr_s = bus.addr; wdata_s = bus.wdata;
            step();
            k++;
            exp_gnt = 3'b000;
            if (k >= next_dec && req_s != 3'b000) begin
                t_port    = pick(req_s, ptr);
                ptr       = t_port;
                exp_owner = t_port;
                exp_gnt   = 3'b001 << t_port;
                g         = k;
                next_dec  = k + MEM_LAT + 2;
                t_we      = we_s[t_port];
                t_addr    = addr_s[t_port*AW +: AW];
                t_wdata   = wdata_s[t_port*DW +: DW];
            end
            exp_en   = (k >= g) && (k < g + MEM_LAT);
            exp_busy = (k >= g) && (k <= g + MEM_LAT);
            exp_ack  = 3'b000;
            if (k == g + MEM_LAT) begin
                exp_ack = 3'b001 << t_port;
                if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
                else      exp_rdata = ref_mem[t_addr[7:0]];
            end
            n_cmp++;
            if ({bus.gnt, mem_en, bus.busy, bus.owner} !== {exp_gnt, exp_en, exp_busy, 2'(exp_owner)}) begin
                n_err++;
                $display("FAIL rand_ctrl k=%0d: gnt=%b en=%b busy=%b owner=%0d, expected %b %b %b %0d",
                         k, bus.gnt, mem_en, bus.busy, bus.owner, exp_gnt, exp_en, exp_busy, exp_owner);
            end
            if (exp_en) begin
                n_cmp++;
                if ({mem_we, mem_addr, mem_wdata} !== {t_we, t_addr, t_wdata}) begin
                    n_err++;
                    $display("FAIL rand_mem k=%0d: we=%b addr=%h wdata=%h, expected %b %h %h",
                             k, mem_we, mem_addr, mem_wdata, t_we, t_addr, t_wdata);
                end
            end
            n_cmp++;
            if ({bus.ack, bus.rdata} !== {exp_ack, exp_rdata}) begin
                n_err++;
                $display("FAIL rand_ack k=%0d: ack=%b rdata=%h, expected %b %h",
                         k, bus.ack, bus.rdata, exp_ack, exp_rdata);
            end
            for (int p = 0; p < 3; p++) begin
                if (bus.gnt[p]) begin
                    pend[p] = 1'b0;
                end else if (pend[p] && $urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end else if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p] = 1'b1;
                    drive(p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 32'($urandom()));
                end
                bus.req[p] = pend[p];
            end
        end
        bus.req = 3'b000;
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1;
        mem_init = 1'b0;
        bus.req = 3'b000; bus.we = 3'b000; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_reset_abort();
        test_rerequest();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
